hazard_unit_mc: RTL and testbench

- Parametrised load-use hazard unit for the 5-stage RISC-V core; sits in ID stage and drives PC write, IF/ID hold and ID/EX bubble insertion.
- Generalises single-cycle load-use detection:
  - configurable multi-cycle load-use stall (LOAD_STALL), tracked by an internal FSM/counter, since the bubble clears IDEX_MemRead_i after one cycle;
  - per-operand use qualification and x0 filtering;
  - data-memory busy freeze with priority over load stalls;
  - saturating performance counters.

---
 rtl/hazard_unit_mc.sv | 101 ++++++++++
 tb/tb_hazard_unit_mc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Load-use hazard unit for the ID stage: multi-cycle load bubbles, data-memory
// freeze with priority, and saturating stall counters.
module hazard_unit_mc #(
    parameter int REG_AW      = 5,
    parameter int LOAD_STALL  = 1,
    parameter int CNT_W       = 32,
    parameter int ZERO_FILTER = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_rd_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              rs1_use_i,
    input  logic              rs2_use_i,
    input  logic              mem_stall_i,
    output logic              PCWrite_o,
    output logic              Stall_o,
    output logic              NoOP_o,
    output logic              MemStall_o,
    output logic [CNT_W-1:0]  load_stall_cnt_o,
    output logic [CNT_W-1:0]  mem_stall_cnt_o
);

    typedef enum logic {RUN, LSTALL} state_t;

    localparam logic [3:0] REM_INIT = 4'(LOAD_STALL - 1);

    state_t     state, state_nxt;
    logic [3:0] rem, rem_nxt;
    logic       hz;
    logic       rd_is_x0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

    assign rd_is_x0 = (ZERO_FILTER != 0) && (IDEX_rd_addr_i == '0);
    assign hz = IDEX_MemRead_i && !rd_is_x0 &&
                ((rs1_use_i && (IDEX_rd_addr_i == rs1_addr_i)) ||
                 (rs2_use_i && (IDEX_rd_addr_i == rs2_addr_i)));

    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        PCWrite_o  = 1'b1;
        Stall_o    = 1'b0;
        NoOP_o     = 1'b0;
        MemStall_o = 1'b0;
        if (rst_i) begin
            state_nxt = RUN;
            rem_nxt   = '0;
        end else if (mem_stall_i) begin
            // Freeze holds the FSM so the bubble count survives the memory stall.
            MemStall_o = 1'b1;
            PCWrite_o  = 1'b0;
            Stall_o    = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz) begin
                        PCWrite_o = 1'b0;
                        Stall_o   = 1'b1;
                        NoOP_o    = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt = LSTALL;
                            rem_nxt   = REM_INIT;
                        end
                    end
                end
                LSTALL: begin
                    PCWrite_o = 1'b0;
                    Stall_o   = 1'b1;
                    NoOP_o    = 1'b1;
                    rem_nxt   = rem - 4'd1;
                    if (rem == 4'd1)
                        state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= RUN;
            rem              <= '0;
            load_stall_cnt_o <= '0;
            mem_stall_cnt_o  <= '0;
        end else begin
            state            <= state_nxt;
            rem              <= rem_nxt;
            load_stall_cnt_o <= sat_inc(load_stall_cnt_o, NoOP_o);
            mem_stall_cnt_o  <= sat_inc(mem_stall_cnt_o, MemStall_o);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomized and directed bench for hazard_unit_mc: three configurations share
// one stimulus stream and are checked against a bubbles-owed reference model.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst, mrd, u1, u2, ms;
    logic [4:0] rd, a1, a2;

    logic [2:0]  pcw, stl, nop, mst;
    logic [31:0] lc0, mc0;
    logic [2:0]  lc1, mc1;
    logic [7:0]  lc2, mc2;
    logic [63:0] lc [3];
    logic [63:0] mc [3];

    int ls [3] = '{1, 3, 2};
    int cw [3] = '{32, 3, 8};
    int zf [3] = '{1, 1, 0};

    int     owed [3];
    longint lcm  [3];
    longint mcm  [3];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(32), .ZERO_FILTER(1)) u0 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mrd), .IDEX_rd_addr_i(rd),
        .rs1_addr_i(a1), .rs2_addr_i(a2), .rs1_use_i(u1), .rs2_use_i(u2),
        .mem_stall_i(ms), .PCWrite_o(pcw[0]), .Stall_o(stl[0]), .NoOP_o(nop[0]),
        .MemStall_o(mst[0]), .load_stall_cnt_o(lc0), .mem_stall_cnt_o(mc0));

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(3), .ZERO_FILTER(1)) u1_dut (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mrd), .IDEX_rd_addr_i(rd),
        .rs1_addr_i(a1), .rs2_addr_i(a2), .rs1_use_i(u1), .rs2_use_i(u2),
        .mem_stall_i(ms), .PCWrite_o(pcw[1]), .Stall_o(stl[1]), .NoOP_o(nop[1]),
        .MemStall_o(mst[1]), .load_stall_cnt_o(lc1), .mem_stall_cnt_o(mc1));

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(2), .CNT_W(8), .ZERO_FILTER(0)) u2_dut (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mrd), .IDEX_rd_addr_i(rd),
        .rs1_addr_i(a1), .rs2_addr_i(a2), .rs1_use_i(u1), .rs2_use_i(u2),
        .mem_stall_i(ms), .PCWrite_o(pcw[2]), .Stall_o(stl[2]), .NoOP_o(nop[2]),
        .MemStall_o(mst[2]), .load_stall_cnt_o(lc2), .mem_stall_cnt_o(mc2));

    assign lc[0] = 64'(lc0);
    assign lc[1] = 64'(lc1);
    assign lc[2] = 64'(lc2);
    assign mc[0] = 64'(mc0);
    assign mc[1] = 64'(mc1);
    assign mc[2] = 64'(mc2);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // A load in EX hurts only if the ID instruction really reads its rd.
    function automatic bit hz_ref(input int i);
        if (!mrd) return 0;
        if (zf[i] != 0 && rd == 0) return 0;
        return (u1 && rd == a1) || (u2 && rd == a2);
    endfunction

    task automatic step(input logic r, input logic m, input int d, input int s1,
                        input int s2, input logic e1, input logic e2, input logic fz);
        bit ep [3], es [3], en [3], em [3];
        int nowed [3];
        @(negedge clk);
        rst = r; mrd = m; rd = 5'(d); a1 = 5'(s1); a2 = 5'(s2);
        u1 = e1; u2 = e2; ms = fz;
        #1;
        for (int i = 0; i < 3; i++) begin
            ep[i] = 1; es[i] = 0; en[i] = 0; em[i] = 0; nowed[i] = owed[i];
            if (r) nowed[i] = 0;
            else if (fz) begin em[i] = 1; es[i] = 1; ep[i] = 0; end
            else if (owed[i] > 0) begin
                en[i] = 1; es[i] = 1; ep[i] = 0; nowed[i] = owed[i] - 1;
            end else if (hz_ref(i)) begin
                en[i] = 1; es[i] = 1; ep[i] = 0; nowed[i] = ls[i] - 1;
            end
            chk($sformatf("pcwrite[%0d]", i), 64'(pcw[i]), 64'(ep[i]));
            chk($sformatf("stall[%0d]", i), 64'(stl[i]), 64'(es[i]));
            chk($sformatf("noop[%0d]", i), 64'(nop[i]), 64'(en[i]));
            chk($sformatf("memstall[%0d]", i), 64'(mst[i]), 64'(em[i]));
            chk($sformatf("lcnt[%0d]", i), lc[i], 64'(lcm[i]));
            chk($sformatf("mcnt[%0d]", i), mc[i], 64'(mcm[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            longint mx = (longint'(1) << cw[i]) - 1;
            owed[i] = nowed[i];
            if (r) begin
                lcm[i] = 0; mcm[i] = 0;
            end else begin
                if (en[i] && lcm[i] < mx) lcm[i]++;
                if (em[i] && mcm[i] < mx) mcm[i]++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; mrd = 0; rd = 0; a1 = 0; a2 = 0; u1 = 0; u2 = 0; ms = 0;
        for (int i = 0; i < 3; i++) begin owed[i] = 0; lcm[i] = 0; mcm[i] = 0; end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 5, 0, 1, 0, 0);
        #1;
        chk("reset_lcnt", lc[1], 64'd0);
        chk("reset_pcwrite", 64'(pcw[1]), 64'd1);

        // lw x5 then consumer of x5; load leaves EX afterwards.
        step(0, 1, 5, 5, 0, 1, 0, 0);
        idle(4);
        #1;
        chk("ls1_cnt", lc[0], 64'd1);
        chk("ls3_cnt", lc[1], 64'd3);
        chk("ls2_cnt", lc[2], 64'd2);

        // x0 loads and unused operands never stall filtered configs.
        step(0, 1, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 1, 7, 1, 7, 1, 0, 0);
        idle(1);

        // Memory stall for two cycles during the second bubble.
        step(0, 1, 9, 9, 9, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);

        // Hazard together with memory stall, then the stall releases.
        step(0, 1, 3, 3, 0, 1, 0, 1);
        step(0, 1, 3, 3, 0, 1, 0, 0);
        idle(4);

        // Nine frozen cycles saturate the 3-bit counter.
        for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("mcnt_sat", mc[1], 64'd7);

        // Reset while the 3-bubble config is mid-stall.
        step(0, 1, 4, 4, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_lstall_pc", 64'(pcw[1]), 64'd1);
        chk("rst_lstall_noop", 64'(nop[1]), 64'd0);
        chk("rst_lstall_lcnt", lc[1], 64'd0);
        chk("rst_lstall_mcnt", mc[1], 64'd0);
        idle(1);

        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
